// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

    // Default number of WAIT cycles before an outstanding request is aborted.
    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating WAIT-cycle counter for the memory arbiter.
// expired_o is high during the enabled cycle that is the TIMEOUT-th since clear_i,
// so the caller can abort at the end of exactly that cycle. TIMEOUT must be >= 1.
module mem_arb_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count enabled cycles, holding at TIMEOUT instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current enabled cycle is the last one allowed
    always_comb begin
        expired_o = en_i && (cnt_q >= CNT_LAST);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch, data) arbiter in front of a single RAM port.
// One transfer at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Build option: define ARB_RR_EN for round-robin on ties; otherwise data wins ties.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_valid,
    output logic        o_if_err,
    output logic [31:0] o_if_data,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [3:0]  i_d_wrmask,
    input  logic [31:0] i_d_data,
    output logic        o_d_valid,
    output logic        o_d_err,
    output logic [31:0] o_d_data,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_wrmask,
    output logic [31:0] o_mem_data,
    input  logic        i_mem_rd_valid,
    input  logic        i_mem_wr_valid,
    input  logic [31:0] i_mem_data
);

    arb_state_e  state_q, state_d;
    port_e       port_q, port_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    port_e       grant;
    logic        any_req;
    logic        timer_clr, timer_en, timer_expired;

    assign any_req = i_if_req | i_d_req;

`ifdef ARB_RR_EN
    port_e last_q, last_d;

    // Remember the most recent grant so that ties alternate between masters
    always_comb begin
        last_d = last_q;
        if ((state_q == IDLE) && any_req) begin
            last_d = grant;
        end
    end

    // Last-grant pointer; starts at fetch so data wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT_IF;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Choose the master that would win if granted this cycle
    always_comb begin
        grant = PORT_IF;
        if (i_d_req) begin
            grant = PORT_D;
        end
`ifdef ARB_RR_EN
        if (i_d_req && i_if_req) begin
            grant = (last_q == PORT_D) ? PORT_IF : PORT_D;
        end
`endif
    end

    // Next-state and transfer-field latching
    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        we_d      = we_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                    port_d  = grant;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (grant == PORT_D) begin
                        we_d    = i_d_we;
                        addr_d  = i_d_addr;
                        // Mask and data only carry meaning for writes
                        mask_d  = i_d_we ? i_d_wrmask : 4'b0000;
                        wdata_d = i_d_we ? i_d_data : 32'h0;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = i_if_addr;
                        mask_d  = 4'b0000;
                        wdata_d = 32'h0;
                    end
                end
            end
            ISSUE: begin
                state_d   = WAIT;
                timer_clr = 1'b1;
            end
            WAIT: begin
                timer_en = 1'b1;
                // Completion of the wrong kind is ignored; a real completion beats timeout
                if (we_q ? i_mem_wr_valid : i_mem_rd_valid) begin
                    rdata_d = we_q ? 32'h0 : i_mem_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timer_expired) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-field registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            port_q  <= PORT_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    mem_arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (timer_clr),
        .en_i     (timer_en),
        .expired_o(timer_expired)
    );

    // Decode outputs from state; everything is forced low while reset is held
    always_comb begin
        o_if_valid   = 1'b0;
        o_if_err     = 1'b0;
        o_if_data    = 32'h0;
        o_d_valid    = 1'b0;
        o_d_err      = 1'b0;
        o_d_data     = 32'h0;
        o_mem_rd     = 1'b0;
        o_mem_wr     = 1'b0;
        o_mem_addr   = 32'h0;
        o_mem_wrmask = 4'b0000;
        o_mem_data   = 32'h0;
        if (!rst) begin
            unique case (state_q)
                ISSUE: begin
                    o_mem_rd     = !we_q;
                    o_mem_wr     = we_q;
                    o_mem_addr   = addr_q;
                    o_mem_wrmask = mask_q;
                    o_mem_data   = wdata_q;
                end
                WAIT: begin
                    o_mem_addr   = addr_q;
                    o_mem_wrmask = mask_q;
                    o_mem_data   = wdata_q;
                end
                RESP: begin
                    if (port_q == PORT_IF) begin
                        o_if_valid = 1'b1;
                        o_if_err   = err_q;
                        o_if_data  = rdata_q;
                    end else begin
                        o_d_valid = 1'b1;
                        o_d_err   = err_q;
                        o_d_data  = rdata_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model.
// Honors ARB_RR_EN the same way as the design build.
module tb_mem_arbiter;

    localparam int TO    = 15;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_valid, o_if_err;
    logic [31:0] o_if_data;
    logic        i_d_req, i_d_we;
    logic [31:0] i_d_addr;
    logic [3:0]  i_d_wrmask;
    logic [31:0] i_d_data;
    logic        o_d_valid, o_d_err;
    logic [31:0] o_d_data;
    logic        o_mem_rd, o_mem_wr;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_wrmask;
    logic [31:0] o_mem_data;
    logic        i_mem_rd_valid, i_mem_wr_valid;
    logic [31:0] i_mem_data;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_if_req      (i_if_req),
        .i_if_addr     (i_if_addr),
        .o_if_valid    (o_if_valid),
        .o_if_err      (o_if_err),
        .o_if_data     (o_if_data),
        .i_d_req       (i_d_req),
        .i_d_we        (i_d_we),
        .i_d_addr      (i_d_addr),
        .i_d_wrmask    (i_d_wrmask),
        .i_d_data      (i_d_data),
        .o_d_valid     (o_d_valid),
        .o_d_err       (o_d_err),
        .o_d_data      (o_d_data),
        .o_mem_rd      (o_mem_rd),
        .o_mem_wr      (o_mem_wr),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wrmask  (o_mem_wrmask),
        .o_mem_data    (o_mem_data),
        .i_mem_rd_valid(i_mem_rd_valid),
        .i_mem_wr_valid(i_mem_wr_valid),
        .i_mem_data    (i_mem_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Master request state: index 0 = fetch, 1 = data
    logic        m_pend [2];
    logic        m_we   [2];
    logic [31:0] m_addr [2];
    logic [3:0]  m_mask [2];
    logic [31:0] m_data [2];

    // Reference transaction: absolute cycle numbers of issue and response
    logic        tr_busy;
    int          tr_port;
    logic        tr_we;
    logic [31:0] tr_addr, tr_wdata, tr_rdata;
    logic [3:0]  tr_mask;
    int          tr_issue, tr_resp, tr_d;
    int          last_grant;

    // Stimulus knobs
    logic        auto_req, force_rd_en, rst_req, cmp_en;
    int          force_d;
    logic [31:0] force_rd;

    // Expected outputs for the current cycle
    logic        e_if_valid, e_if_err, e_d_valid, e_d_err, e_mem_rd, e_mem_wr;
    logic [31:0] e_if_data, e_d_data, e_mem_addr, e_mem_data;
    logic [3:0]  e_mem_mask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic new_req(input int p);
        m_pend[p] = 1'b1;
        m_addr[p] = $urandom;
        if (p == 0) begin
            m_we[p]   = 1'b0;
            m_mask[p] = 4'h0;
            m_data[p] = 32'h0;
        end else begin
            m_we[p]   = 1'($urandom_range(1));
            m_mask[p] = 4'($urandom);
            m_data[p] = m_we[p] ? $urandom : 32'h0;
        end
    endtask

    // Drive one cycle of inputs and advance the reference model by that cycle
    task automatic step();
        int w;
        rst = rst_req;
        if (auto_req) begin
            for (int p = 0; p < 2; p++) begin
                if (!m_pend[p] && ($urandom_range(99) < 35)) new_req(p);
            end
        end
        i_if_req   = m_pend[0];
        i_if_addr  = m_addr[0];
        i_d_req    = m_pend[1];
        i_d_we     = m_we[1];
        i_d_addr   = m_addr[1];
        i_d_wrmask = m_mask[1];
        i_d_data   = m_data[1];

        // RAM: completes on WAIT cycle tr_d, otherwise may raise wrong-kind flags
        i_mem_rd_valid = 1'b0;
        i_mem_wr_valid = 1'b0;
        i_mem_data     = $urandom;
        if (tr_busy && (cyc > tr_issue) && (cyc < tr_resp)) begin
            if (cyc - tr_issue == tr_d) begin
                if (tr_we) begin
                    i_mem_wr_valid = 1'b1;
                end else begin
                    i_mem_rd_valid = 1'b1;
                    i_mem_data     = tr_rdata;
                end
            end else if ($urandom_range(3) == 0) begin
                if (tr_we) i_mem_rd_valid = 1'b1;
                else i_mem_wr_valid = 1'b1;
            end
        end else if (!tr_busy && ($urandom_range(7) == 0)) begin
            i_mem_rd_valid = 1'($urandom_range(1));
            i_mem_wr_valid = 1'($urandom_range(1));
        end

        e_if_valid = 1'b0; e_if_err = 1'b0; e_if_data = 32'h0;
        e_d_valid  = 1'b0; e_d_err  = 1'b0; e_d_data  = 32'h0;
        e_mem_rd   = 1'b0; e_mem_wr = 1'b0;
        e_mem_addr = 32'h0; e_mem_mask = 4'h0; e_mem_data = 32'h0;

        if (rst_req) begin
            tr_busy    = 1'b0;
            last_grant = 0;
        end else if (!tr_busy) begin
            if (m_pend[0] || m_pend[1]) begin
                if (m_pend[0] && m_pend[1]) begin
`ifdef ARB_RR_EN
                    w = (last_grant == 1) ? 0 : 1;
`else
                    w = 1;
`endif
                end else begin
                    w = m_pend[1] ? 1 : 0;
                end
                last_grant = w;
                tr_busy    = 1'b1;
                tr_port    = w;
                tr_we      = m_we[w];
                tr_addr    = m_addr[w];
                tr_mask    = tr_we ? m_mask[w] : 4'h0;
                tr_wdata   = tr_we ? m_data[w] : 32'h0;
                tr_issue   = cyc + 1;
                if (force_d >= 0) tr_d = force_d;
                else if ($urandom_range(9) < 7) tr_d = int'($urandom_range(4, 1));
                else tr_d = int'($urandom_range(TO + 3, 1));
                tr_rdata = force_rd_en ? force_rd : $urandom;
                tr_resp  = tr_issue + 1 + ((tr_d <= TO) ? tr_d : TO);
            end
        end else begin
            if ((cyc >= tr_issue) && (cyc < tr_resp)) begin
                e_mem_addr = tr_addr;
                e_mem_mask = tr_mask;
                e_mem_data = tr_wdata;
                if (cyc == tr_issue) begin
                    e_mem_rd = !tr_we;
                    e_mem_wr = tr_we;
                end
            end
            if (cyc == tr_resp) begin
                if (tr_port == 0) begin
                    e_if_valid = 1'b1;
                    e_if_err   = (tr_d > TO);
                    e_if_data  = (tr_d <= TO) ? tr_rdata : 32'h0;
                end else begin
                    e_d_valid = 1'b1;
                    e_d_err   = (tr_d > TO);
                    e_d_data  = ((tr_d <= TO) && !tr_we) ? tr_rdata : 32'h0;
                end
                tr_busy         = 1'b0;
                m_pend[tr_port] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        step();
        #1;
    endtask

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        #2;
        if (cmp_en) begin
            check("if_valid",   32'(o_if_valid),   32'(e_if_valid));
            check("if_err",     32'(o_if_err),     32'(e_if_err));
            check("if_data",    o_if_data,         e_if_data);
            check("d_valid",    32'(o_d_valid),    32'(e_d_valid));
            check("d_err",      32'(o_d_err),      32'(e_d_err));
            check("d_data",     o_d_data,          e_d_data);
            check("mem_rd",     32'(o_mem_rd),     32'(e_mem_rd));
            check("mem_wr",     32'(o_mem_wr),     32'(e_mem_wr));
            check("mem_addr",   o_mem_addr,        e_mem_addr);
            check("mem_wrmask", 32'(o_mem_wrmask), 32'(e_mem_mask));
            check("mem_data",   o_mem_data,        e_mem_data);
        end
    end

    initial begin
        int seq, nresp, d_left, seen;
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 1'b0; m_we[p] = 1'b0; m_addr[p] = 32'h0;
            m_mask[p] = 4'h0; m_data[p] = 32'h0;
        end
        tr_busy = 1'b0; tr_port = 0; tr_we = 1'b0; tr_addr = 32'h0; tr_wdata = 32'h0;
        tr_rdata = 32'h0; tr_mask = 4'h0; tr_issue = 0; tr_resp = 0; tr_d = 0;
        last_grant = 0;
        auto_req = 1'b0; force_rd_en = 1'b0; force_rd = 32'h0; force_d = -1;
        rst_req = 1'b1; rst = 1'b1; cmp_en = 1'b1;
        e_if_valid = 1'b0; e_if_err = 1'b0; e_if_data = 32'h0;
        e_d_valid = 1'b0; e_d_err = 1'b0; e_d_data = 32'h0;
        e_mem_rd = 1'b0; e_mem_wr = 1'b0; e_mem_addr = 32'h0; e_mem_mask = 4'h0;
        e_mem_data = 32'h0;
        i_if_req = 1'b0; i_if_addr = 32'h0; i_d_req = 1'b0; i_d_we = 1'b0;
        i_d_addr = 32'h0; i_d_wrmask = 4'h0; i_d_data = 32'h0;
        i_mem_rd_valid = 1'b0; i_mem_wr_valid = 1'b0; i_mem_data = 32'h0;

        repeat (3) tick();
        check("reset_mem_rd", 32'(o_mem_rd), 32'd0);
        check("reset_d_valid", 32'(o_d_valid), 32'd0);
        rst_req = 1'b0;
        repeat (2) tick();

        // Fetch read of 0x100 returning 0xDEADBEEF after one WAIT cycle
        m_pend[0] = 1'b1; m_addr[0] = 32'h100;
        force_d = 1; force_rd_en = 1'b1; force_rd = 32'hDEADBEEF;
        tick();
        check("fetch_n_rd", 32'(o_mem_rd), 32'd0);
        tick();
        check("fetch_issue_rd", 32'(o_mem_rd), 32'd1);
        check("fetch_issue_addr", o_mem_addr, 32'h100);
        check("fetch_issue_mask", 32'(o_mem_wrmask), 32'd0);
        tick();
        check("fetch_wait_rd", 32'(o_mem_rd), 32'd0);
        check("fetch_wait_valid", 32'(o_if_valid), 32'd0);
        tick();
        check("fetch_resp_valid", 32'(o_if_valid), 32'd1);
        check("fetch_resp_data", o_if_data, 32'hDEADBEEF);
        check("fetch_resp_err", 32'(o_if_err), 32'd0);
        tick();
        check("fetch_after_valid", 32'(o_if_valid), 32'd0);

        // Data write 0x1234 to 0x204 with mask 0011
        m_pend[1] = 1'b1; m_we[1] = 1'b1; m_addr[1] = 32'h204;
        m_mask[1] = 4'b0011; m_data[1] = 32'h1234;
        tick();
        tick();
        check("wr_issue_wr", 32'(o_mem_wr), 32'd1);
        check("wr_issue_rd", 32'(o_mem_rd), 32'd0);
        check("wr_issue_addr", o_mem_addr, 32'h204);
        check("wr_issue_mask", 32'(o_mem_wrmask), 32'h3);
        check("wr_issue_data", o_mem_data, 32'h1234);
        tick();
        check("wr_wait_wr", 32'(o_mem_wr), 32'd0);
        tick();
        check("wr_resp_valid", 32'(o_d_valid), 32'd1);
        check("wr_resp_data", o_d_data, 32'h0);
        tick();

        // Tie-break order after a fresh reset: data issues three back-to-back requests
        rst_req = 1'b1; tick(); rst_req = 1'b0;
        force_rd_en = 1'b0;
        m_pend[0] = 1'b1; m_addr[0] = 32'h300;
        m_pend[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 32'h400; m_mask[1] = 4'h0;
        m_data[1] = 32'h0;
        d_left = 2; seq = 0; nresp = 0;
        for (int t = 0; t < 60 && nresp < 4; t++) begin
            tick();
            if (o_d_valid) begin
                seq = (seq << 4) | 1; nresp++;
                if (d_left > 0) begin d_left--; m_pend[1] = 1'b1; end
            end
            if (o_if_valid) begin seq = (seq << 4) | 2; nresp++; end
        end
`ifdef ARB_RR_EN
        check("tie_order", 32'(seq), 32'h1211);
`else
        check("tie_order", 32'(seq), 32'h1112);
`endif

        // Unanswered read: error response exactly TO WAIT cycles after ISSUE
        m_pend[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 32'hDEAD0000; m_mask[1] = 4'hF;
        force_d = NEVER;
        tick();
        tick();
        check("to_issue_rd", 32'(o_mem_rd), 32'd1);
        check("to_issue_mask", 32'(o_mem_wrmask), 32'd0);
        seen = 0;
        for (int k = 0; k < TO; k++) begin
            tick();
            if (o_d_valid) seen++;
        end
        check("to_no_early_valid", 32'(seen), 32'd0);
        tick();
        check("to_resp_valid", 32'(o_d_valid), 32'd1);
        check("to_resp_err", 32'(o_d_err), 32'd1);
        check("to_resp_data", o_d_data, 32'h0);
        tick();

        // Reset during WAIT aborts silently; the held request is then served normally
        m_pend[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 32'h500; m_mask[1] = 4'h0;
        force_d = NEVER;
        repeat (3) tick();
        rst_req = 1'b1;
        tick();
        check("rst_wait_d_valid", 32'(o_d_valid), 32'd0);
        check("rst_wait_addr", o_mem_addr, 32'h0);
        rst_req = 1'b0; force_d = 1; force_rd_en = 1'b1; force_rd = 32'hCAFEF00D;
        seen = 0;
        tick();
        seen += int'(o_d_valid);
        check("rerq_idle_rd", 32'(o_mem_rd), 32'd0);
        tick();
        seen += int'(o_d_valid);
        check("rerq_issue_rd", 32'(o_mem_rd), 32'd1);
        check("rerq_issue_addr", o_mem_addr, 32'h500);
        tick();
        seen += int'(o_d_valid);
        tick();
        check("rerq_resp_valid", 32'(o_d_valid), 32'd1);
        check("rerq_resp_data", o_d_data, 32'hCAFEF00D);
        check("rst_no_pulse", 32'(seen), 32'd0);
        tick();

        // Randomized traffic with occasional reset pulses
        force_d = -1; force_rd_en = 1'b0; auto_req = 1'b1;
        for (int t = 0; t < 4000; t++) begin
            rst_req = ($urandom_range(299) == 0);
            tick();
        end
        auto_req = 1'b0; rst_req = 1'b0;
        for (int t = 0; t < 200 && (m_pend[0] || m_pend[1] || tr_busy); t++) tick();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
